// File: rtl/sha3_pkg.sv
// sha3_pkg: shared types and constants for the SHA3 absorb controller.
//   mode_e      : hash mode encoding (3 bits when SHA3_SHAKE_EN is defined, else 2 bits)
//   state_e     : absorb controller FSM states
//   RATE_LANES  : rate in 64-bit lanes for a given mode
//   IS_SHAKE    : SHAKE domain select (only with SHA3_SHAKE_EN)
// Optional feature macro: SHA3_SHAKE_EN (adds SHAKE128/SHAKE256 modes).
package sha3_pkg;

`ifdef SHA3_SHAKE_EN
    localparam int unsigned MODE_W = 3;
    typedef enum logic [2:0] {
        ModeSha3_224 = 3'b000,
        ModeSha3_256 = 3'b001,
        ModeSha3_384 = 3'b010,
        ModeSha3_512 = 3'b011,
        ModeShake128 = 3'b100,
        ModeShake256 = 3'b101
    } mode_e;
`else
    localparam int unsigned MODE_W = 2;
    typedef enum logic [1:0] {
        ModeSha3_224 = 2'b00,
        ModeSha3_256 = 2'b01,
        ModeSha3_384 = 2'b10,
        ModeSha3_512 = 2'b11
    } mode_e;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPad,
        StPerm,
        StFin
    } state_e;

    localparam logic [7:0]  DOMAIN_SHA3  = 8'h06;
    localparam logic [7:0]  DOMAIN_SHAKE = 8'h1F;
    localparam logic [63:0] PAD_END      = 64'h8000_0000_0000_0000;
    localparam int unsigned LANES        = 25;

    // Rate in lanes; unlisted codes fall back to SHA3-256.
    function automatic logic [4:0] RATE_LANES(input mode_e mode);
        logic [4:0] rate;
        rate = 5'd17;
        case (mode)
            ModeSha3_224: rate = 5'd18;
            ModeSha3_256: rate = 5'd17;
            ModeSha3_384: rate = 5'd13;
            ModeSha3_512: rate = 5'd9;
`ifdef SHA3_SHAKE_EN
            ModeShake128: rate = 5'd21;
            ModeShake256: rate = 5'd17;
`endif
            default:      rate = 5'd17;
        endcase
        return rate;
    endfunction

`ifdef SHA3_SHAKE_EN
    function automatic logic IS_SHAKE(input mode_e mode);
        return (mode == ModeShake128) || (mode == ModeShake256);
    endfunction
`endif

endpackage

// File: rtl/sha3_pad_lane.sv
// sha3_pad_lane: combinational SHA3/SHAKE pad lane generator.
//   lane_idx      : lane currently being padded
//   first_pad_idx : first lane after the message data (gets the domain byte)
//   rate          : rate in lanes (last lane gets the final pad bit)
//   shake         : selects the SHAKE domain byte instead of SHA3
//   lane_data     : pad lane value
module sha3_pad_lane
    import sha3_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned LANE_W = 5
) (
    input  logic [LANE_W-1:0] lane_idx,
    input  logic [LANE_W-1:0] first_pad_idx,
    input  logic [LANE_W-1:0] rate,
    input  logic              shake,
    output logic [WIDTH-1:0]  lane_data
);

    logic [7:0] domain;

    always_comb begin
        domain    = shake ? DOMAIN_SHAKE : DOMAIN_SHA3;
        lane_data = '0;
        // Both terms OR together when the first pad lane is also the last lane.
        if (lane_idx == first_pad_idx) begin
            lane_data[7:0] = domain;
        end
        if (lane_idx == rate - LANE_W'(1)) begin
            lane_data = lane_data | PAD_END;
        end
    end

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// sha3_absorb_ctrl: sequences the SHA3 absorb phase.
//   Reads message lanes from the input FIFO, presents them as indexed lanes
//   (lane_valid/lane_idx/lane_data) to the state XOR datapath, inserts pad
//   lanes, and fires perm_start after each rate block.
//   Ports: clk/reset (async active-high), start/mode/msg_words (message setup),
//   fifo_empty/fifo_dout/fifo_rd_en (FIFO read side), lane_* (datapath),
//   perm_start/perm_done (Keccak core handshake), busy/done (status).
// Optional feature macro: SHA3_SHAKE_EN (3-bit mode with SHAKE128/SHAKE256).
module sha3_absorb_ctrl
    import sha3_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned LANE_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic [LEN_W-1:0]  msg_words,
    input  logic              fifo_empty,
    input  logic [WIDTH-1:0]  fifo_dout,
    output logic              fifo_rd_en,
    output logic              lane_valid,
    output logic [LANE_W-1:0] lane_idx,
    output logic [WIDTH-1:0]  lane_data,
    output logic              perm_start,
    input  logic              perm_done,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [LANE_W-1:0] rate_q, rate_d;
    logic [LANE_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
    logic [LANE_W-1:0] first_pad_q, first_pad_d;
    logic [LANE_W-1:0] rd_idx_q, rd_idx_d;
    logic [LEN_W-1:0]  words_left_q, words_left_d;
    logic              shake_q, shake_d;
    logic              pad_done_q, pad_done_d;
    logic              rd_pend_q, rd_pend_d;
    logic              perm_sent_q, perm_sent_d;
    logic              rd_en;
    logic [WIDTH-1:0]  pad_data;

    sha3_pad_lane #(
        .WIDTH  (WIDTH),
        .LANE_W (LANE_W)
    ) u_pad_lane (
        .lane_idx      (lane_cnt_q),
        .first_pad_idx (first_pad_q),
        .rate          (rate_q),
        .shake         (shake_q),
        .lane_data     (pad_data)
    );

    always_comb begin
        state_d      = state_q;
        rate_d       = rate_q;
        issue_cnt_d  = issue_cnt_q;
        lane_cnt_d   = lane_cnt_q;
        first_pad_d  = first_pad_q;
        rd_idx_d     = rd_idx_q;
        words_left_d = words_left_q;
        shake_d      = shake_q;
        pad_done_d   = pad_done_q;
        rd_pend_d    = 1'b0;
        perm_sent_d  = 1'b0;
        rd_en        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rate_d       = LANE_W'(RATE_LANES(mode_e'(mode)));
`ifdef SHA3_SHAKE_EN
                    shake_d      = IS_SHAKE(mode_e'(mode));
`else
                    shake_d      = 1'b0;
`endif
                    words_left_d = msg_words;
                    issue_cnt_d  = '0;
                    lane_cnt_d   = '0;
                    first_pad_d  = '0;
                    pad_done_d   = 1'b0;
                    state_d      = (msg_words != '0) ? StLoad : StPad;
                end
            end
            StLoad: begin
                rd_en = !fifo_empty && (words_left_q != '0) && (issue_cnt_q < rate_q);
                if (rd_en) begin
                    rd_pend_d    = 1'b1;
                    rd_idx_d     = issue_cnt_q;
                    issue_cnt_d  = issue_cnt_q + LANE_W'(1);
                    words_left_d = words_left_q - LEN_W'(1);
                end else if (!rd_pend_q) begin
                    // Leave only once the last read's lane has been presented.
                    if (issue_cnt_q == rate_q) begin
                        state_d = StPerm;
                    end else if (words_left_q == '0) begin
                        state_d     = StPad;
                        lane_cnt_d  = issue_cnt_q;
                        first_pad_d = issue_cnt_q;
                    end
                end
            end
            StPad: begin
                if (lane_cnt_q == rate_q - LANE_W'(1)) begin
                    pad_done_d = 1'b1;
                    state_d    = StPerm;
                end else begin
                    lane_cnt_d = lane_cnt_q + LANE_W'(1);
                end
            end
            StPerm: begin
                perm_sent_d = 1'b1;
                if (perm_done) begin
                    perm_sent_d = 1'b0;
                    if (pad_done_q) begin
                        state_d = StFin;
                    end else if (words_left_q != '0) begin
                        state_d     = StLoad;
                        issue_cnt_d = '0;
                    end else begin
                        // Message ended on a block boundary: full pad block.
                        state_d     = StPad;
                        lane_cnt_d  = '0;
                        first_pad_d = '0;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        fifo_rd_en = rd_en;
        lane_valid = 1'b0;
        lane_idx   = '0;
        lane_data  = '0;
        if (state_q == StPad) begin
            lane_valid = 1'b1;
            lane_idx   = lane_cnt_q;
            lane_data  = pad_data;
        end else if (rd_pend_q) begin
            lane_valid = 1'b1;
            lane_idx   = rd_idx_q;
            lane_data  = fifo_dout;
        end
        perm_start = (state_q == StPerm) && !perm_sent_q;
        busy       = (state_q != StIdle);
        done       = (state_q == StFin);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            rate_q       <= '0;
            issue_cnt_q  <= '0;
            lane_cnt_q   <= '0;
            first_pad_q  <= '0;
            rd_idx_q     <= '0;
            words_left_q <= '0;
            shake_q      <= 1'b0;
            pad_done_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
            perm_sent_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rate_q       <= rate_d;
            issue_cnt_q  <= issue_cnt_d;
            lane_cnt_q   <= lane_cnt_d;
            first_pad_q  <= first_pad_d;
            rd_idx_q     <= rd_idx_d;
            words_left_q <= words_left_d;
            shake_q      <= shake_d;
            pad_done_q   <= pad_done_d;
            rd_pend_q    <= rd_pend_d;
            perm_sent_q  <= perm_sent_d;
        end
    end

endmodule

// File: tb/tb_sha3_absorb_ctrl.sv
// tb_sha3_absorb_ctrl: scoreboard bench for sha3_absorb_ctrl (default build, SHA3 modes).
module tb_sha3_absorb_ctrl;
    import sha3_pkg::*;

    localparam int unsigned WIDTH  = 64;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned LANE_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [MODE_W-1:0] mode;
    logic [LEN_W-1:0]  msg_words;
    logic              fifo_empty;
    logic [WIDTH-1:0]  fifo_dout = '0;
    logic              fifo_rd_en;
    logic              lane_valid;
    logic [LANE_W-1:0] lane_idx;
    logic [WIDTH-1:0]  lane_data;
    logic              perm_start;
    logic              perm_done = 1'b0;
    logic              busy;
    logic              done;

    sha3_absorb_ctrl #(
        .WIDTH  (WIDTH),
        .LEN_W  (LEN_W),
        .LANE_W (LANE_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .msg_words  (msg_words),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .lane_valid (lane_valid),
        .lane_idx   (lane_idx),
        .lane_data  (lane_data),
        .perm_start (perm_start),
        .perm_done  (perm_done),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_perm  = 0;
    int n_done  = 0;
    int n_rd    = 0;

    // FIFO model: registered read data.
    logic [63:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Keccak core model: perm_done pulses a few cycles after perm_start.
    int perm_cnt = 0;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            perm_cnt  <= 0;
            perm_done <= 1'b0;
        end else begin
            perm_done <= (perm_cnt == 1);
            if (perm_start) perm_cnt <= 4;
            else if (perm_cnt > 0) perm_cnt <= perm_cnt - 1;
        end
    end

    // Scoreboard of expected lanes.
    logic [LANE_W-1:0] exp_idx[$];
    logic [63:0]       exp_data[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_rd_en) n_rd++;
            if (perm_start) n_perm++;
            if (done) n_done++;
            if (fifo_rd_en && fifo_empty) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_when_empty: got fifo_rd_en=1, required 0 while FIFO empty");
            end
            if (lane_valid) begin
                n_tests++;
                if (exp_idx.size() == 0) begin
                    n_fail++;
                    $display("FAIL lane_unexpected: got idx %0d data %h, required no lane",
                             lane_idx, lane_data);
                end else begin
                    logic [LANE_W-1:0] ei;
                    logic [63:0]       ed;
                    ei = exp_idx.pop_front();
                    ed = exp_data.pop_front();
                    if (lane_idx !== ei || lane_data !== ed) begin
                        n_fail++;
                        $display("FAIL lane: got idx %0d data %h, required idx %0d data %h",
                                 lane_idx, lane_data, ei, ed);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_fifo(input logic [63:0] d);
        mem[wr_ptr[7:0]] = d;
        wr_ptr++;
    endtask

    task automatic expect_lane(input int idx, input logic [63:0] d);
        exp_idx.push_back(LANE_W'(idx));
        exp_data.push_back(d);
    endtask

    // Queue expected pad lanes p..r-1 for a block whose data ended at lane p.
    task automatic expect_pad(input int p, input int r);
        for (int j = p; j < r; j++) begin
            expect_lane(j, ((j == p) ? 64'h06 : 64'h0) |
                           ((j == r - 1) ? 64'h8000_0000_0000_0000 : 64'h0));
        end
    endtask

    task automatic issue_start(input int m, input int words);
        @(negedge clk);
        start     = 1'b1;
        mode      = MODE_W'(m);
        msg_words = LEN_W'(words);
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0);
        int k;
        k = 0;
        while (n_done == d0 && k < 2000) begin
            @(posedge clk);
            k++;
        end
        check({name, "_done_seen"}, 64'(n_done != d0), 64'd1);
    endtask

    // Full message run: words of data starting at seed, rate r, hand-derived perm count.
    task automatic run_msg(input string name, input int m, input int r, input int words,
                           input logic [63:0] seed, input int exp_perms);
        int p0, d0, r0;
        p0 = n_perm;
        d0 = n_done;
        r0 = n_rd;
        for (int i = 0; i < words; i++) begin
            push_fifo(seed + 64'(i));
            expect_lane(i % r, seed + 64'(i));
        end
        expect_pad(words % r, r);
        issue_start(m, words);
        wait_done(name, d0);
        repeat (3) @(posedge clk);
        check({name, "_perm_count"}, 64'(n_perm - p0), 64'(exp_perms));
        check({name, "_rd_count"}, 64'(n_rd - r0), 64'(words));
        check({name, "_done_count"}, 64'(n_done - d0), 64'd1);
        check({name, "_lanes_left"}, 64'(exp_idx.size()), 64'd0);
        check({name, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0, k;
        reset     = 1'b1;
        start     = 1'b0;
        mode      = '0;
        msg_words = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_outputs", {59'(0), fifo_rd_en, lane_valid, perm_start, done, 1'b0}, 64'd0);
        reset = 1'b0;

        // SHA3-256, 3 words: data lanes 0-2, lane3=0x06, lane16=0x80<<56.
        run_msg("sha3_256_w3", 1, 17, 3, 64'h1111_0000_0000_0000, 1);
        // SHA3-512, exact block fill: second block is a full pad block.
        run_msg("sha3_512_w9", 3, 9, 9, 64'h2222_0000_0000_0000, 2);
        // SHA3-224, 17 words: lane17 = 0x8000_0000_0000_0006.
        run_msg("sha3_224_w17", 0, 18, 17, 64'h3333_0000_0000_0000, 1);
        // SHA3-384, empty message: pad only, no FIFO reads.
        run_msg("sha3_384_w0", 2, 13, 0, 64'h0, 1);

        // SHA3-256 with a mid-block FIFO stall, then reset during PERM.
        p0 = n_perm;
        for (int i = 0; i < 5; i++) begin
            push_fifo(64'h4444_0000_0000_0000 + 64'(i));
            expect_lane(i, 64'h4444_0000_0000_0000 + 64'(i));
        end
        issue_start(1, 20);
        repeat (12) @(posedge clk);
        for (int i = 5; i < 17; i++) begin
            push_fifo(64'h4444_0000_0000_0000 + 64'(i));
            expect_lane(i, 64'h4444_0000_0000_0000 + 64'(i));
        end
        k = 0;
        while (n_perm == p0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        check("stall_perm_seen", 64'(n_perm - p0), 64'd1);
        check("stall_lanes_left", 64'(exp_idx.size()), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_outputs", {59'(0), fifo_rd_en, lane_valid, perm_start, done, 1'b0}, 64'd0);
        check("midreset_lane_idx", 64'(lane_idx), 64'd0);
        check("midreset_lane_data", lane_data, 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        wr_ptr = rd_ptr;
        repeat (20) @(posedge clk);
        check("midreset_no_perm", 64'(n_perm - p0), 64'd1);
        check("midreset_idle", 64'(busy), 64'd0);

        // Clean run after the aborted message.
        run_msg("post_reset_w3", 1, 17, 3, 64'h5555_0000_0000_0000, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
